// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_SUB_WIDTH = 8;

    // The 2'b11 encoding is illegal; the FSM recovers it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } sub_state_e;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_sub_cell.sv
// One-bit full-subtractor cell: d = a - b - bin, with a borrow-out.
// This is purely combinational; the caller owns the borrow register.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_sub_cell

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first.
// Operands come in on a valid/ready handshake; diff/bout go out on another.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    sub_state_e       state_r;
    sub_state_e       state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_r;
    logic             br_r;
    logic             bout_r;
    logic [CNT_W-1:0] cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic             d_s;
    logic             br_nxt_s;
    logic             last_bit_s;
    logic             accept_s;
    logic [WIDTH:0]   diff_cat_s;

    full_sub_cell u_cell (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (br_nxt_s)
    );

    assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
    assign accept_s   = in_valid & in_ready_r;
    // Concatenation lets the diff shift work for WIDTH=1 as well.
    assign diff_cat_s = {d_s, diff_r};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; the illegal encoding falls through to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake/status flags are registered from the next state so they track state_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s == ST_RUN);
        end
    end

    // Operand capture, serial datapath shift and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            diff_r <= {WIDTH{1'b0}};
            br_r   <= 1'b0;
            bout_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r   <= a;
                        b_r   <= b;
                        br_r  <= bin;
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    a_r    <= a_r >> 1;
                    b_r    <= b_r >> 1;
                    diff_r <= diff_cat_s[WIDTH:1];
                    br_r   <= br_nxt_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (last_bit_s) begin
                        bout_r <= br_nxt_s;
                    end
                end
                default: begin
                    // DONE and illegal states hold the datapath.
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign diff      = diff_r;
    assign bout      = bout_r;

endmodule : serial_subtractor
